// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (16-bit word count, big-endian words,
// 8-bit checksum) and writes each assembled word, holding the CPU via busy until verified.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'd0,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS) + 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLenHi = 3'd1;
    localparam logic [2:0] StLenLo = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
    localparam logic [2:0] StErr   = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [15:0]     count_q, count_d;
    logic [IdxW-1:0] widx_q, widx_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [23:0]     shift_q, shift_d;
    logic [7:0]      csum_q, csum_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic        in_ready;
    logic        xfer;
    logic [15:0] len_full;
    logic        last_word;

    assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCsum);
    assign xfer      = in_valid_i && in_ready;
    assign len_full  = {count_q[15:8], in_data_i};
    assign last_word = ((32'(widx_q) + 32'd1) == 32'(count_q));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d = StLenHi;
                    count_d = '0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    shift_d = '0;
                    csum_d  = '0;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    count_d[15:8] = in_data_i;
                    state_d       = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    count_d = len_full;
                    if (32'(len_full) > DEPTH_WORDS) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    csum_d  = csum_q + in_data_i;
                    bidx_d  = bidx_q + 2'd1;
                    shift_d = {shift_q[15:0], in_data_i};
                    // Fourth byte completes the word; the write is registered for next cycle.
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + (32'(widx_q) << 2);
                        wdata_d = {shift_q, in_data_i};
                        widx_d  = widx_q + IdxW'(1);
                        if (last_word) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = (in_data_i == csum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    // The last word's write lands in CSUM, but busy must cover it regardless.
    assign busy_o      = in_ready || we_q;
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand-written reset/throttle/start sequences and random
// images checked against a frame-level model; a second instance verifies a non-zero base.
module tb_imem_loader;

    localparam int unsigned Depth = 256;
    localparam logic [31:0] BaseB = 32'h100;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    imem_loader #(.BASE_ADDR(32'd0), .DEPTH_WORDS(Depth)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .busy_o(busy), .done_o(done), .err_o(err)
    );

    imem_loader #(.BASE_ADDR(BaseB), .DEPTH_WORDS(Depth)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   wr_cnt  = 0;
    logic prev_we = 1'b0;

    // Every write is popped against the model's expectation, including its cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            chk("we_gap", 64'(prev_we), 64'd0);
            chk("we_b", 64'(mem_we_b), 64'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
                chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("wr_addr_b", 64'(mem_addr_b), 64'(mon_e.addr + BaseB));
                chk("wr_data_b", 64'(mem_wdata_b), 64'(mon_e.data));
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [7:0] img_q[$];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int hs);
        in_data  = b;
        in_valid = 1'b1;
        hs       = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                hs = cyc;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Frame-level model: count = first two bytes, then 4*count data bytes, then checksum.
    task automatic run_image(input int gmin, input int gmax, input int start_at,
                             input bit finish, output bit exp_done, output bit exp_err);
        int         cnt;
        int         hs;
        int         w;
        int         g;
        logic [7:0] sum;
        logic [31:0] word;
        bit         len_bad;
        bit         csum_ok;
        cnt = -1; w = 0; sum = 8'd0; word = 32'd0; len_bad = 1'b0; csum_ok = 1'b0;
        pulse_start();
        for (int i = 0; i < img_q.size(); i++) begin
            send_byte(img_q[i], hs);
            if (hs < 0) begin
                chk("handshake_timeout", 64'd1, 64'd0);
                break;
            end
            if (i == 1) begin
                cnt = int'({img_q[0], img_q[1]});
                len_bad = (cnt > int'(Depth));
            end else if (i >= 2 && i < 2 + 4 * cnt) begin
                sum  = sum + img_q[i];
                word = {word[23:0], img_q[i]};
                if ((i - 2) % 4 == 3) begin
                    exp_q.push_back('{addr: 32'(4 * w), data: word, cyc: hs});
                    w++;
                end
            end else if (i >= 2 && i == 2 + 4 * cnt) begin
                csum_ok = (img_q[i] == sum);
            end
            if (i == start_at) pulse_start();
            g = int'($urandom_range(gmax, gmin));
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        exp_err  = len_bad || !csum_ok;
        exp_done = !exp_err;
        if (finish) begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            chk("end_done", 64'(done), 64'(exp_done));
            chk("end_err", 64'(err), 64'(exp_err));
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_in_ready", 64'(in_ready), 64'd0);
            chk("end_pending_writes", 64'(exp_q.size()), 64'd0);
            chk("end_done_b", 64'(done_b), 64'(exp_done));
        end
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [95:0] b;
        bit          done;
        bit          err;
        int          nw;
    } vec_t;

    vec_t vecs[5];

    task automatic load_vec(input vec_t v);
        img_q.delete();
        for (int k = 0; k < v.n; k++) img_q.push_back(v.b[95 - 8 * k -: 8]);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        bit ed, ee;
        int w0, cnt, r;
        logic [7:0] s, bt;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        vecs[0] = '{name: "two_words",  n: 11, b: 96'h0002_2000_0003_2421_0004_6C00,
                    done: 1'b1, err: 1'b0, nw: 2};
        vecs[1] = '{name: "bad_csum",   n: 11, b: 96'h0002_2000_0003_2421_0004_6B00,
                    done: 1'b0, err: 1'b1, nw: 2};
        vecs[2] = '{name: "too_long",   n: 2,  b: 96'h0101_0000_0000_0000_0000_0000,
                    done: 1'b0, err: 1'b1, nw: 0};
        vecs[3] = '{name: "empty_ok",   n: 3,  b: 96'h0000_0000_0000_0000_0000_0000,
                    done: 1'b1, err: 1'b0, nw: 0};
        vecs[4] = '{name: "empty_bad",  n: 3,  b: 96'h0000_0100_0000_0000_0000_0000,
                    done: 1'b0, err: 1'b1, nw: 0};

        #12;
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[v]) begin
            load_vec(vecs[v]);
            w0 = wr_cnt;
            run_image(0, 0, -1, 1'b1, ed, ee);
            chk({vecs[v].name, "_done"}, 64'(done), 64'(vecs[v].done));
            chk({vecs[v].name, "_err"}, 64'(err), 64'(vecs[v].err));
            chk({vecs[v].name, "_writes"}, 64'(wr_cnt - w0), 64'(vecs[v].nw));
        end

        // Throttled: valid low every other cycle.
        load_vec(vecs[0]);
        w0 = wr_cnt;
        run_image(1, 1, -1, 1'b1, ed, ee);
        chk("throttle_done", 64'(done), 64'd1);
        chk("throttle_writes", 64'(wr_cnt - w0), 64'd2);

        // start pulsed mid-load must be ignored.
        load_vec(vecs[0]);
        run_image(0, 0, 3, 1'b1, ed, ee);
        chk("start_busy_done", 64'(done), 64'd1);

        // Reset after six data bytes: one write lands, then everything clears.
        load_vec(vecs[0]);
        img_q = img_q[0:7];
        w0 = wr_cnt;
        run_image(0, 0, -1, 1'b0, ed, ee);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort");
        chk("abort_writes", 64'(wr_cnt - w0), 64'd1);
        chk("abort_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_idle_done", 64'(done), 64'd0);
        load_vec(vecs[0]);
        run_image(0, 0, -1, 1'b1, ed, ee);
        chk("after_abort_done", 64'(done), 64'd1);

        // Random images; the first fills the memory to capacity.
        for (int it = 0; it < 20; it++) begin
            r = int'($urandom_range(9, 0));
            if (it == 0) cnt = int'(Depth);
            else if (r == 0) cnt = int'(Depth) + 1 + int'($urandom_range(1000, 0));
            else cnt = int'($urandom_range(5, 0));
            img_q.delete();
            img_q.push_back(8'(cnt >> 8));
            img_q.push_back(8'(cnt));
            if (cnt <= int'(Depth)) begin
                s = 8'd0;
                for (int k = 0; k < 4 * cnt; k++) begin
                    bt = 8'($urandom);
                    s  = s + bt;
                    img_q.push_back(bt);
                end
                if ($urandom_range(3, 0) == 0) s = s + 8'd1 + 8'($urandom_range(254, 0));
                img_q.push_back(s);
            end
            w0 = wr_cnt;
            run_image(0, 2, -1, 1'b1, ed, ee);
            chk("rand_writes", 64'(wr_cnt - w0), 64'((cnt <= int'(Depth)) ? cnt : 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
